packet_injector: RTL and testbench
==================================

PACKET_INJECTOR -- requirements
Module: packet_injector

Interface
REQ-001 Parameters SHALL be: ModuleID, default 6'b000_000, sender ID stamped into packets; dataWidth, default 32, packet width; dim, default 4, mesh dimension.
REQ-002 Port clk  input  1  clock, all state updates on rising edge.
REQ-003 Port reset  input  1  asynchronous, active-low reset.
REQ-004 Port Enable  input  1  level; permits new packet generation.
REQ-005 Port DestID  input  6  fixed destination {x[2:0],y[2:0]} when RandDest=0.
REQ-006 Port RandDest  input  1  1 selects pseudo-random destination.
REQ-007 Port GapCycles  input  8  idle cycles between packets.
REQ-008 Port NumPackets  input  10  packets to send; 0 means unlimited.
REQ-009 Port PacketOut  output  dataWidth  packet to router local input port.
REQ-010 Port ReqDnStr  output  1  request to router local port.
REQ-011 Port GntDnStr  input  1  grant from router local port.
REQ-012 Port DnStrFull  input  1  router local input buffer full.
REQ-013 Port SentCount  output  10  packets granted since reset.
REQ-014 Port Done  output  1  NumPackets reached (sticky).

Function
REQ-015 Packet format SHALL be: [31:22] zero, [21:16] destination, [15:6] PacketID, [5:0] ModuleID.
REQ-016 FSM states SHALL be IDLE, GAP, REQ, RELEASE; all outputs registered.
REQ-017 IDLE: Enable=1 and Done=0 -> GAP, gap counter loaded with GapCycles.
REQ-018 GAP: counter decrements each cycle; at counter==0 and DnStrFull=0 -> REQ, PacketOut latched, ReqDnStr set to 1 on that same edge; counter==0 with DnStrFull=1 -> stay GAP.
REQ-019 GapCycles=0: ReqDnStr SHALL rise on the 2nd rising edge after Enable is sampled high in IDLE.
REQ-020 REQ: ReqDnStr=1 and PacketOut held stable until GntDnStr sampled 1; then -> RELEASE, ReqDnStr<=0, SentCount+1, PacketID+1.
REQ-021 Request SHALL never be withdrawn: Enable low or DnStrFull high during REQ SHALL not deassert ReqDnStr.
REQ-022 RELEASE: wait until GntDnStr sampled 0; then if NumPackets!=0 and SentCount==NumPackets -> Done<=1, IDLE; else Enable=1 -> GAP (reload), Enable=0 -> IDLE.
REQ-023 PacketID SHALL be 10 bits starting at 0, wrapping 1023->0; SentCount SHALL saturate at 1023.
REQ-024 Random destination SHALL come from a 16-bit Fibonacci LFSR (taps 16,14,13,11, seed 16'hACE1) advanced once per packet latch; dest = lfsr[5:0], and if equal to ModuleID, dest = lfsr[5:0]^6'b000_001.
REQ-025 Destination x or y field >= dim SHALL be reduced modulo dim before stamping.
REQ-026 Done SHALL block new packets until reset; NumPackets changes after Done have no effect.
REQ-027 At most one request SHALL be outstanding; no pipelining of packets.

Reset
REQ-028 reset=0 SHALL asynchronously force: state IDLE, ReqDnStr 0, PacketOut 0, PacketID 0, SentCount 0, Done 0, gap counter 0, LFSR 16'hACE1.
REQ-029 Reset mid-REQ SHALL drop ReqDnStr immediately; the in-flight packet is not counted.
REQ-030 After reset release, first packet SHALL carry PacketID 0.

Structure
REQ-031 Shared package SHALL hold packet field offsets/widths (DEST, PKTID, SENDER), the state encoding and the LFSR seed/tap constants.
REQ-032 One sub-module SHALL exist: injector_lfsr (16-bit LFSR, advance strobe, async active-low reset to seed).

Verification
REQ-033 GapCycles=0, NumPackets=3, DestID=6'b001_010, grant 1 cycle after Req -> three packets, PacketIDs 0,1,2, PacketOut=32'h000A_0000|ID<<6|ModuleID, Done=1, SentCount=3.
REQ-034 GapCycles=5 -> exactly 5 GAP cycles between ReqDnStr fall/Gnt-low and next GAP exit; Req rises 7 edges after previous RELEASE exit decision.
REQ-035 DnStrFull=1 for 10 cycles while in GAP with counter 0 -> ReqDnStr stays 0, rises on edge after DnStrFull falls.
REQ-036 Grant delayed 20 cycles, Enable dropped mid-REQ -> ReqDnStr and PacketOut stable 20 cycles, packet completes, then IDLE.
REQ-037 NumPackets=0, 1030 packets -> PacketID wraps 1023->0, SentCount saturates 1023, Done stays 0.
REQ-038 RandDest=1, ModuleID=6'b000_001, reset asserted mid-REQ -> Req drops same cycle, no dest equals ModuleID, post-reset sequence repeats identical LFSR destinations.

Source files
------------

// File: rtl/packet_injector_pkg.sv
// packet_injector_pkg: packet field layout, FSM encoding and LFSR constants
package packet_injector_pkg;
    localparam int DEST_OFF   = 16;
    localparam int DEST_W     = 6;
    localparam int PKTID_OFF  = 6;
    localparam int PKTID_W    = 10;
    localparam int SENDER_OFF = 0;
    localparam int SENDER_W   = 6;
    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    // x^16+x^14+x^13+x^11+1 in shift-right form taps bits 0,2,3,5
    localparam logic [15:0] LFSR_TAPS = 16'h002D;
    typedef enum logic [1:0] {IDLE, GAP, REQ, RELEASE} state_e;
    function automatic logic [5:0] fold_dest(logic [5:0] d, int dim_v);
        return {3'(int'(d[5:3]) % dim_v), 3'(int'(d[2:0]) % dim_v)};
    endfunction
endpackage

// File: rtl/packet_injector_if.sv
// packet_injector_if: request/grant link between the injector and the router local port
interface packet_injector_if #(
    parameter int dataWidth = 32
);
    logic [dataWidth-1:0] PacketOut;
    logic                 ReqDnStr;
    logic                 GntDnStr;
    logic                 DnStrFull;
    modport master(output PacketOut, ReqDnStr, input GntDnStr, DnStrFull);
    modport slave(input PacketOut, ReqDnStr, output GntDnStr, DnStrFull);
endinterface

// File: rtl/packet_injector_lfsr.sv
// injector_lfsr: 16-bit Fibonacci LFSR stepped by a strobe, low 6 bits feed the random destination
module injector_lfsr
    import packet_injector_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       adv_i,
    output logic [5:0] rnd_o
);
    logic [15:0] lfsr_q, lfsr_d;
    always_comb lfsr_d = adv_i ? {^(lfsr_q & LFSR_TAPS), lfsr_q[15:1]} : lfsr_q;
    always_ff @(posedge clk or negedge reset)
        if (!reset) lfsr_q <= LFSR_SEED;
        else lfsr_q <= lfsr_d;
    assign rnd_o = lfsr_q[5:0];
endmodule

// File: rtl/packet_injector.sv
// packet_injector: traffic generator feeding one packet at a time into a mesh router local port
module packet_injector
    import packet_injector_pkg::*;
#(
    parameter logic [5:0] ModuleID  = 6'b000_000,
    parameter int         dataWidth = 32,
    parameter int         dim       = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       Enable,
    input  logic [5:0] DestID,
    input  logic       RandDest,
    input  logic [7:0] GapCycles,
    input  logic [9:0] NumPackets,
    packet_injector_if.master dn,
    output logic [9:0] SentCount,
    output logic       Done
);
    state_e               state_q, state_d;
    logic [7:0]           cnt_q, cnt_d;
    logic [dataWidth-1:0] pkt_q, pkt_d, pkt_new;
    logic                 req_q, req_d, done_q, done_d, adv;
    logic [9:0]           pid_q, pid_d, sent_q, sent_d;
    logic [5:0]           rnd, dest_fold, dest;

    injector_lfsr u_lfsr (.clk(clk), .reset(reset), .adv_i(adv), .rnd_o(rnd));

    // fold into the mesh first so the self-avoidance flip sees the final address
    assign dest_fold = fold_dest(RandDest ? rnd : DestID, dim);
    assign dest = (RandDest && dest_fold == ModuleID) ? dest_fold ^ 6'b000_001 : dest_fold;

    always_comb begin
        pkt_new = '0;
        pkt_new[DEST_OFF +: DEST_W] = dest;
        pkt_new[PKTID_OFF +: PKTID_W] = pid_q;
        pkt_new[SENDER_OFF +: SENDER_W] = ModuleID;
    end

    always_comb begin
        state_d = state_q;
        cnt_d = cnt_q;
        pkt_d = pkt_q;
        req_d = req_q;
        pid_d = pid_q;
        sent_d = sent_q;
        done_d = done_q;
        adv = 1'b0;
        case (state_q)
            IDLE:
                if (Enable && !done_q) begin
                    state_d = GAP;
                    cnt_d = GapCycles;
                end
            GAP:
                if (cnt_q != 8'd0) cnt_d = cnt_q - 8'd1;
                else if (!dn.DnStrFull) begin
                    state_d = REQ;
                    req_d = 1'b1;
                    pkt_d = pkt_new;
                    adv = 1'b1;
                end
            REQ:
                if (dn.GntDnStr) begin
                    state_d = RELEASE;
                    req_d = 1'b0;
                    sent_d = (sent_q == 10'h3FF) ? sent_q : sent_q + 10'd1;
                    pid_d = pid_q + 10'd1;
                end
            RELEASE:
                if (!dn.GntDnStr) begin
                    if (NumPackets != 10'd0 && sent_q == NumPackets) begin
                        done_d = 1'b1;
                        state_d = IDLE;
                    end else if (Enable) begin
                        state_d = GAP;
                        cnt_d = GapCycles;
                    end else state_d = IDLE;
                end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            state_q <= IDLE;
            cnt_q <= '0;
            pkt_q <= '0;
            req_q <= 1'b0;
            pid_q <= '0;
            sent_q <= '0;
            done_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q <= cnt_d;
            pkt_q <= pkt_d;
            req_q <= req_d;
            pid_q <= pid_d;
            sent_q <= sent_d;
            done_q <= done_d;
        end

    assign dn.PacketOut = pkt_q;
    assign dn.ReqDnStr = req_q;
    assign SentCount = sent_q;
    assign Done = done_q;
endmodule

// File: tb/tb_packet_injector.sv
// tb_packet_injector: random traffic against a packet-level reference model of the injector
module tb_packet_injector;
    localparam logic [5:0] MID = 6'b000_001;
    localparam int DIM = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       enable = 1'b0;
    logic [5:0] dest_id = '0;
    logic       rand_dest = 1'b0;
    logic [7:0] gap_cycles = '0;
    logic [9:0] num_packets = '0;
    logic [9:0] sent_count;
    logic       done;
    int         n_cmp = 0;
    int         n_bad = 0;
    int         pid_m, sent_m;
    logic [15:0] lfsr_m;
    logic [5:0]  cur_dest;
    logic [31:0] cur_pkt;
    logic [5:0]  first_dests [4];

    packet_injector_if #(.dataWidth(32)) dn_if ();

    packet_injector #(.ModuleID(MID), .dataWidth(32), .dim(DIM)) dut (
        .clk(clk), .reset(reset), .Enable(enable), .DestID(dest_id), .RandDest(rand_dest),
        .GapCycles(gap_cycles), .NumPackets(num_packets), .dn(dn_if.master),
        .SentCount(sent_count), .Done(done)
    );

    always #5 clk = ~clk;

    initial begin
        #2ms;
        $display("FAIL watchdog: run did not finish, compared %0d", n_cmp);
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [15:0] lfsr_next(logic [15:0] l);
        logic [15:0] b;
        b = (l ^ (l >> 2) ^ (l >> 3) ^ (l >> 5)) & 16'd1;
        return (l >> 1) | (b << 15);
    endfunction

    function automatic logic [5:0] model_dest(logic rnd, logic [5:0] fixed, logic [15:0] l);
        int raw, d;
        raw = rnd ? int'(l[5:0]) : int'(fixed);
        d = ((raw / 8) % DIM) * 8 + (raw % 8) % DIM;
        if (rnd && d == int'(MID)) d = d ^ 1;
        return 6'(d);
    endfunction

    task automatic reset_model();
        pid_m = 0;
        sent_m = 0;
        lfsr_m = 16'hACE1;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        enable = 1'b0;
        dn_if.GntDnStr = 1'b0;
        dn_if.DnStrFull = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        reset_model();
    endtask

    // next posedge is the launch decision; Full is held high for edges 1..full_n
    task automatic wait_req(input int gap, input int full_n);
        int k, exp_k;
        gap_cycles = 8'(gap);
        exp_k = (gap + 2 > full_n + 1) ? gap + 2 : full_n + 1;
        k = 0;
        dn_if.DnStrFull = (full_n >= 1);
        while (dn_if.ReqDnStr !== 1'b1 && k < exp_k + 40) begin
            @(negedge clk);
            k++;
            dn_if.DnStrFull = (full_n >= k + 1);
        end
        dn_if.DnStrFull = 1'b0;
        check("req_latency", 32'(k), 32'(exp_k));
        cur_dest = model_dest(rand_dest, dest_id, lfsr_m);
        cur_pkt = 32'((int'(cur_dest) << 16) | (pid_m << 6) | int'(MID));
        lfsr_m = lfsr_next(lfsr_m);
        check("packet", dn_if.PacketOut, cur_pkt);
        if (rand_dest) check("dest_not_self", 32'(dn_if.PacketOut[21:16] != MID), 32'd1);
    endtask

    task automatic finish_packet(input int gnt_dly, input bit drop_en);
        if (drop_en) begin
            enable = 1'b0;
            dn_if.DnStrFull = 1'b1;
        end
        repeat (gnt_dly) begin
            @(negedge clk);
            check("req_hold", 32'(dn_if.ReqDnStr), 32'd1);
            check("pkt_hold", dn_if.PacketOut, cur_pkt);
        end
        dn_if.DnStrFull = 1'b0;
        dn_if.GntDnStr = 1'b1;
        @(negedge clk);
        pid_m = (pid_m + 1) % 1024;
        if (sent_m < 1023) sent_m++;
        check("req_drop", 32'(dn_if.ReqDnStr), 32'd0);
        check("sent_count", 32'(sent_count), 32'(sent_m));
        dn_if.GntDnStr = 1'b0;
    endtask

    task automatic run_packet(input int gap, input int full_n, input int gnt_dly, input bit drop_en);
        wait_req(gap, full_n);
        finish_packet(gnt_dly, drop_en);
    endtask

    initial begin
        int hits;
        dn_if.GntDnStr = 1'b0;
        dn_if.DnStrFull = 1'b0;
        @(negedge clk);
        check("rst_req", 32'(dn_if.ReqDnStr), 32'd0);
        check("rst_pkt", dn_if.PacketOut, 32'd0);
        check("rst_sent", 32'(sent_count), 32'd0);
        check("rst_done", 32'(done), 32'd0);

        // three fixed-destination packets then sticky Done
        do_reset();
        dest_id = 6'b001_010;
        num_packets = 10'd3;
        enable = 1'b1;
        for (int i = 0; i < 3; i++) begin
            wait_req(0, 0);
            if (i == 0) check("first_pkt", dn_if.PacketOut, 32'h000A_0001);
            finish_packet(0, 1'b0);
        end
        @(negedge clk);
        check("done", 32'(done), 32'(num_packets != 0 && sent_m == int'(num_packets)));
        check("sent3", 32'(sent_count), 32'd3);
        num_packets = 10'd7;
        hits = 0;
        repeat (12) begin
            @(negedge clk);
            if (dn_if.ReqDnStr) hits++;
        end
        check("done_blocks", 32'(hits), 32'd0);
        check("done_sticky", 32'(done), 32'd1);

        // gap timing, full back-pressure and random traffic
        do_reset();
        num_packets = 10'd0;
        enable = 1'b1;
        run_packet(5, 0, 1, 1'b0);
        run_packet(5, 0, 0, 1'b0);
        run_packet(3, 14, 1, 1'b0);
        for (int i = 0; i < 40; i++) begin
            dest_id = 6'($urandom);
            rand_dest = 1'($urandom);
            run_packet($urandom_range(0, 7), $urandom_range(0, 12), $urandom_range(0, 4), 1'b0);
        end

        // long grant with Enable dropped and Full raised mid-request
        run_packet(2, 0, 20, 1'b1);
        hits = 0;
        repeat (6) begin
            @(negedge clk);
            if (dn_if.ReqDnStr) hits++;
        end
        check("idle_after_drop", 32'(hits), 32'd0);
        enable = 1'b1;
        run_packet(1, 0, 0, 1'b0);

        // unlimited run across the PacketID wrap and SentCount saturation
        do_reset();
        rand_dest = 1'b0;
        dest_id = 6'($urandom);
        num_packets = 10'd0;
        enable = 1'b1;
        for (int i = 0; i < 1030; i++) run_packet(0, 0, $urandom_range(0, 1), 1'b0);
        check("sent_sat", 32'(sent_count), 32'd1023);
        check("no_done", 32'(done), 32'd0);

        // random destinations, reset in flight, identical sequence afterwards
        do_reset();
        rand_dest = 1'b1;
        enable = 1'b1;
        for (int i = 0; i < 4; i++) begin
            wait_req($urandom_range(0, 3), 0);
            first_dests[i] = cur_dest;
            finish_packet($urandom_range(0, 2), 1'b0);
        end
        wait_req(0, 0);
        reset = 1'b0;
        #1;
        check("rst_mid_req", 32'(dn_if.ReqDnStr), 32'd0);
        check("rst_mid_sent", 32'(sent_count), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        reset_model();
        for (int i = 0; i < 4; i++) begin
            wait_req($urandom_range(0, 3), 0);
            check("dest_repeat", 32'(dn_if.PacketOut[21:16]), 32'(first_dests[i]));
            finish_packet(0, 1'b0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
